// File: rtl/decim_sample_fifo.sv
// ---------------------------------------------------------------------------
// decim_sample_fifo
//   First-word-fall-through sample FIFO that sits behind a decimating filter.
//   A sample is pushed on each in_ce strobe. A sample is dropped only when the
//   FIFO is full and nothing is popped in the same cycle. A sticky overflow flag
//   records drops. Full and empty are tracked with a level counter, so the
//   read and write pointers may be equal in both states.
//
//   Optional feature: define DECIM_FIFO_DROP_CNT_EN to build a saturating
//   16-bit drop counter. Without the macro, drop_count is tied to zero.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_data    in   DW   signed decimated sample, qualified by in_ce
//   in_ce      in   1    sample strobe
//   out_data   out  DW   head-of-FIFO sample (0 while empty)
//   out_valid  out  1    FIFO non-empty
//   out_ready  in   1    consumer accept; pop when out_valid && out_ready
//   level      out  AW+1 number of stored samples, 0..DEPTH
//   overflow   out  1    sticky drop flag
//   clr_ovf    in   1    synchronous clear of overflow and drop_count
//   drop_count out  16   saturating drop counter (optional)
// ---------------------------------------------------------------------------
module decim_sample_fifo #(
   parameter int  DW    = 16,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] in_data,
   input  logic                 in_ce,
   output logic signed [DW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AW:0]          level,
   output logic                 overflow,
   input  logic                 clr_ovf,
   output logic [15:0]          drop_count
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic signed [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic                 ovf_q, ovf_d;
   logic                 pop, push, drop;

   always_comb begin
      pop  = (level_q != '0) && out_ready;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      push = in_ce && ((level_q != FULL_LVL) || pop);
      drop = in_ce && (level_q == FULL_LVL) && !pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      level_d = level_q;
      if (push && !pop)
         level_d = level_q + 1'b1;
      else if (pop && !push)
         level_d = level_q - 1'b1;

      // A drop in the same cycle as clr_ovf leaves the flag set.
      if (drop)
         ovf_d = 1'b1;
      else if (clr_ovf)
         ovf_d = 1'b0;
      else
         ovf_d = ovf_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; the level counter alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= in_data;
   end

   assign out_valid = (level_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign level     = level_q;
   assign overflow  = ovf_q;

`ifdef DECIM_FIFO_DROP_CNT_EN
   logic [15:0] dcnt_q, dcnt_d;

   always_comb begin
      dcnt_d = dcnt_q;
      if (clr_ovf)
         dcnt_d = drop ? 16'd1 : 16'd0;
      else if (drop && (dcnt_q != 16'hFFFF))
         dcnt_d = dcnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dcnt_q <= 16'd0;
      else
         dcnt_q <= dcnt_d;
   end

   assign drop_count = dcnt_q;
`else
   assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_decim_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_decim_sample_fifo
//   Self-checking bench for decim_sample_fifo. It uses a vector table for the
//   basic push/pop behaviour, hand-written sequences for fill/drop, full
//   push+pop, wrap, clr_ovf collision and asynchronous reset, and a random
//   phase. Every cycle is also compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_decim_sample_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_data;
   logic        in_ce;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  level;
   logic        overflow;
   logic        clr_ovf;
   logic [15:0] drop_count;

   decim_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_ce      (in_ce),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a queue of stored samples plus the sticky flag and drop count.
   logic [15:0] mq[$];
   logic        m_ovf;
   int          m_drops;

   typedef struct packed {
      logic        ce;
      logic [15:0] d;
      logic        rdy;
      logic        clr;
      logic        e_vld;
      logic [15:0] e_data;
      logic [4:0]  e_lvl;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_dc();
`ifdef DECIM_FIFO_DROP_CNT_EN
      return 16'(m_drops);
`else
      return 16'd0;
`endif
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
      check({tag, ".data"},  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check({tag, ".level"}, 32'(level),     32'(mq.size()));
      check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, ".dcnt"},  32'(drop_count), 32'(exp_dc()));
   endtask

   // Drive one cycle, advance the model by the rules, and compare after the edge.
   task automatic step(input logic ce, input logic [15:0] d, input logic rdy,
                       input logic clr, input string tag);
      logic popped, dropped;
      @(negedge clk);
      in_ce     = ce;
      in_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      popped  = (mq.size() != 0) && rdy;
      dropped = 1'b0;
      if (popped) void'(mq.pop_front());
      if (ce) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) m_drops = dropped ? 1 : 0;
      else if (dropped && m_drops < 65535) m_drops++;
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_ce     = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      #1;
      check_model("reset");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_ce     = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      m_ovf     = 1'b0;
      m_drops   = 0;

      //           ce   data      rdy  clr  vld  data      lvl  ovf
      tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 5'd1, 1'b0};
      tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0};
      tbl[2] = '{1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'hABCD, 5'd1, 1'b0};
      tbl[3] = '{1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h5555, 5'd1, 1'b0};
      tbl[4] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h5555, 5'd1, 1'b0};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0};
      tbl[6] = '{1'b0, 16'h8001, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0};
      tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0};

      // Single sample and basic push/pop via the vector table.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].ce, tbl[i].d, tbl[i].rdy, tbl[i].clr, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.t_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
         check($sformatf("vec%0d.t_data", i),  32'(out_data),  32'(tbl[i].e_data));
         check($sformatf("vec%0d.t_level", i), 32'(level),     32'(tbl[i].e_lvl));
         check($sformatf("vec%0d.t_ovf", i),   32'(overflow),  32'(tbl[i].e_ovf));
      end

      // Fill and drop.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0, "fill");
      for (int i = 0; i < 3; i++) step(1'b1, 16'(100 + i), 1'b0, 1'b0, "drop");
      check("fill.level", 32'(level), 32'd16);
      check("fill.ovf", 32'(overflow), 32'd1);
`ifdef DECIM_FIFO_DROP_CNT_EN
      check("fill.dcnt", 32'(drop_count), 32'd3);
`else
      check("fill.dcnt", 32'(drop_count), 32'd0);
`endif
      for (int i = 0; i < 16; i++) begin
         check("fill.drain", 32'(out_data), 32'(i));
         step(1'b0, 16'h0, 1'b1, 1'b0, "drain");
      end
      check("fill.empty", 32'(out_valid), 32'd0);

      // Full with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0, "full");
      step(1'b1, 16'd99, 1'b1, 1'b0, "fullpp");
      check("fullpp.level", 32'(level), 32'd16);
      check("fullpp.ovf", 32'(overflow), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         check("fullpp.drain", 32'(out_data), (i == 16) ? 32'd99 : 32'(i));
         step(1'b0, 16'h0, 1'b1, 1'b0, "fulldrain");
      end

      // Wrap: 40 push/pop pairs, push every 4th cycle.
      do_reset();
      for (int k = 0; k < 40; k++) begin
         logic [15:0] d;
         d = 16'($urandom);
         step(1'b1, d, 1'b1, 1'b0, "wrap");
         check("wrap.data", 32'(out_data), 32'(d));
         check("wrap.lvl_le1", 32'(level <= 5'd1), 32'd1);
         for (int j = 0; j < 3; j++) step(1'b0, 16'(~d), 1'b1, 1'b0, "wrapidle");
      end
      check("wrap.ovf", 32'(overflow), 32'd0);

      // clr_ovf colliding with a drop.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i + 7), 1'b0, 1'b0, "cfill");
      step(1'b1, 16'hDEAD, 1'b0, 1'b1, "collide");
      check("collide.ovf", 32'(overflow), 32'd1);
`ifdef DECIM_FIFO_DROP_CNT_EN
      check("collide.dcnt", 32'(drop_count), 32'd1);
`endif
      step(1'b0, 16'h0, 1'b0, 1'b1, "clralone");
      check("clralone.ovf", 32'(overflow), 32'd0);
      check("clralone.dcnt", 32'(drop_count), 32'd0);

      // Asynchronous reset mid-cycle with level=7 and overflow set.
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 16'(i + 300), 1'b0, 1'b0, "afill");
      for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 1'b1, 1'b0, "apop");
      check("areset.pre_level", 32'(level), 32'd7);
      #2;
      reset     = 1'b1;
      in_ce     = 1'b0;
      out_ready = 1'b0;
      #1;
      check("areset.valid", 32'(out_valid), 32'd0);
      check("areset.level", 32'(level), 32'd0);
      check("areset.ovf", 32'(overflow), 32'd0);
      check("areset.dcnt", 32'(drop_count), 32'd0);
      check("areset.data", 32'(out_data), 32'd0);
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 16'h7777, 1'b0, 1'b0, "apost");
      check("apost.data", 32'(out_data), 32'h7777);
      check("apost.level", 32'(level), 32'd1);

      // Randomized traffic against the model, alternating drain-heavy and fill-heavy phases.
      do_reset();
      for (int n = 0; n < 800; n++) begin
         logic rdy;
         rdy = ((n / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(1'($urandom_range(0, 1)), 16'($urandom), rdy,
              ($urandom_range(0, 19) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decim_sample_fifo.md
DECIM_SAMPLE_FIFO -- requirements
Module: decim_sample_fifo

Interface
REQ-001 Parameter DW, default 16, sample width in bits; matches the decimating filter's filter_out.
REQ-002 Parameter DEPTH, default 16, FIFO depth in samples; power of 2, at least 4.
REQ-003 Parameter AW, default $clog2(DEPTH), address width; derived, not overridden.
REQ-004 clk  in  1  single system clock, rising edge; all logic in this domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_data  in  DW  signed decimated sample, qualified by in_ce.
REQ-007 in_ce  in  1  one-cycle strobe, connects to the decimator's ce_out; sample present when high.
REQ-008 out_data  out  DW  head-of-FIFO sample, first-word-fall-through.
REQ-009 out_valid  out  1  FIFO non-empty.
REQ-010 out_ready  in  1  consumer accept; pop occurs when out_valid and out_ready are both high.
REQ-011 level  out  AW+1  samples currently stored, 0..DEPTH.
REQ-012 overflow  out  1  sticky flag: a sample was dropped.
REQ-013 clr_ovf  in  1  synchronous clear of overflow and drop_count.
REQ-014 drop_count  out  16  count of dropped samples; see Configuration.

Function
REQ-015 Push condition: in_ce high and (level < DEPTH, or a pop occurs in the same cycle).
- Pushed sample is written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-016 Pop: rd_ptr increments modulo DEPTH; out_data shows the next entry in the following cycle.
REQ-017 Latency: a sample pushed at edge N gives out_valid=1 with that data after edge N; no same-cycle bypass when empty.
REQ-018 Level update per cycle: push only +1; pop only -1; push and pop together, no change.
REQ-019 out_valid = (level != 0).
- out_data is DW'd0 whenever out_valid = 0; otherwise it equals mem[rd_ptr].
REQ-020 Drop: in_ce high, level = DEPTH, no pop that cycle. The sample is discarded, storage is unchanged, and overflow is set on the next edge.
REQ-021 clr_ovf and a drop in the same cycle: overflow stays 1 (set wins).
REQ-022 Pointers wrap without loss.
- Full and empty are distinguished by level, not by pointer equality.
REQ-023 out_ready high while empty has no effect: no pop, rd_ptr unchanged.
REQ-024 in_data is sampled only when in_ce is high; in_data changes with in_ce low have no effect.

Reset
REQ-025 On reset assertion, immediately and independent of clk, all of the following are forced to 0:
- wr_ptr, rd_ptr, level, out_valid, out_data, overflow, drop_count.
REQ-026 Memory contents are not reset.
REQ-027 Reset mid-stream discards all stored samples.
- The first in_ce after reset deassertion is accepted normally.

Configuration
REQ-028 Macro DECIM_FIFO_DROP_CNT_EN.
REQ-029 With DECIM_FIFO_DROP_CNT_EN defined, drop_count behaves as follows:
- Increments by 1 per drop (REQ-020) and saturates at 16'hFFFF.
- clr_ovf alone clears it to 0.
- clr_ovf together with a drop loads 1.
REQ-030 Without the macro, drop_count is tied to 16'd0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-031 Single sample: reset, then in_ce=1 for 1 cycle with in_data=16'h1234 and out_ready=0.
- Expected: out_valid=1, out_data=16'h1234, level=1 one cycle later.
- Then out_ready=1 for 1 cycle: expected out_valid=0, out_data=0, level=0.
REQ-032 Fill and drop: push 16 samples 0..15 with out_ready=0, then 3 more (100, 101, 102).
- Expected: level=16, overflow=1, drop_count=3 (macro on) or 0 (macro off).
- Draining yields 0..15 in order.
REQ-033 Full with simultaneous push and pop: fill to 16, then push 99 in the same cycle as a pop.
- Expected: level stays 16, overflow stays 0.
- Draining yields 1..15 then 99.
REQ-034 Wrap: 40 push/pop pairs at in_ce every 4th cycle with out_ready=1.
- Expected: output sequence equals input, level never exceeds 1, no overflow.
REQ-035 clr_ovf/drop collision: with the FIFO full, assert clr_ovf and in_ce together.
- Expected: overflow=1; drop_count=1 (macro on).
- Next cycle, clr_ovf alone: overflow=0, drop_count=0.
REQ-036 Async reset: assert reset mid-cycle with level=7.
- Expected: out_valid, level, overflow, drop_count all 0 before the next clk edge.
- After release, the first pushed sample appears at out_data.
